// File: rtl/m_unit_iter.sv
// m_unit_iter: iterative RV32M-style execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Holds one operation at a time. Operands become magnitudes when the op is accepted.
// Multiplication is shift-add, MUL_STEP multiplier bits per cycle.
// Division is restoring, one quotient bit per cycle.
// A single FIXUP cycle then applies the result signs.
// Divide-by-zero and signed overflow are resolved when the op is accepted.
module m_unit_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    localparam int MUL_CYC = XLEN / MUL_STEP;
    localparam int CW      = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_CYC - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [2*XLEN-1:0] acc_reg, mcand_reg;
    logic [XLEN-1:0]   mplier_reg, rem_reg, quo_reg, divisor_reg, result_reg;
    logic [CW-1:0]     cnt_reg;
    logic [2:0]        op_reg;
    logic              a_neg_reg, b_neg_reg;

    logic              signed_a, signed_b, a_neg, b_neg;
    logic              div_zero, div_ovf, special, accept;
    logic [XLEN-1:0]   a_mag, b_mag, special_val;

    logic [2*XLEN-1:0] pp [MUL_STEP];
    logic [2*XLEN-1:0] mul_add, prod_fix;
    logic [XLEN:0]     rem_shift, rem_diff;
    logic              rem_ge, res_neg;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    assign in_ready   = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign out_valid  = (state_reg == S_DONE);
    assign out_result = result_reg;
    assign accept     = in_valid && in_ready && !flush;

    // Decode of a new request: signedness, magnitudes and the cases that bypass the datapath
    always_comb begin
        signed_a    = op[2] ? !op[0] : (op[1:0] != 2'b11);
        signed_b    = op[2] ? !op[0] : !op[1];
        a_neg       = signed_a && operand_a[XLEN-1];
        b_neg       = signed_b && operand_b[XLEN-1];
        a_mag       = a_neg ? -operand_a : operand_a;
        b_mag       = b_neg ? -operand_b : operand_b;
        div_zero    = op[2] && (operand_b == '0);
        div_ovf     = op[2] && !op[0] && (operand_a == MIN_INT) && (operand_b == {XLEN{1'b1}});
        special     = div_zero || div_ovf;
        special_val = '0;
        if (div_zero) begin
            special_val = op[1] ? operand_a : {XLEN{1'b1}};
        end else if (div_ovf) begin
            special_val = op[1] ? '0 : MIN_INT;
        end
    end

    // One partial product per multiplier bit retired this cycle
    genvar gi;
    generate
        for (gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    // Per-cycle step values for both iterative engines, plus the sign fixup
    always_comb begin
        mul_add = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            mul_add = mul_add + pp[j];
        end
        rem_shift  = {rem_reg, quo_reg[XLEN-1]};
        rem_ge     = (rem_shift >= {1'b0, divisor_reg});
        rem_diff   = rem_shift - {1'b0, divisor_reg};
        res_neg    = a_neg_reg ^ b_neg_reg;
        prod_fix   = res_neg ? -acc_reg : acc_reg;
        quo_fix    = res_neg ? -quo_reg : quo_reg;
        rem_fix    = a_neg_reg ? -rem_reg : rem_reg;
        if (op_reg[2]) begin
            fix_result = op_reg[1] ? rem_fix : quo_fix;
        end else begin
            fix_result = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush wins over everything except reset
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = special ? S_DONE : (op[2] ? S_DIV : S_MUL);
            S_MUL:   if (cnt_reg == MUL_LAST) state_next = S_FIXUP;
            S_DIV:   if (cnt_reg == DIV_LAST) state_next = S_FIXUP;
            S_FIXUP: state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // Datapath: latch at accept, iterate in MUL/DIV, sign-correct in FIXUP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            result_reg  <= '0;
            cnt_reg     <= '0;
            op_reg      <= '0;
            a_neg_reg   <= 1'b0;
            b_neg_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg      <= op;
                        a_neg_reg   <= a_neg;
                        b_neg_reg   <= b_neg;
                        acc_reg     <= '0;
                        mcand_reg   <= {{XLEN{1'b0}}, a_mag};
                        mplier_reg  <= b_mag;
                        rem_reg     <= '0;
                        quo_reg     <= a_mag;
                        divisor_reg <= b_mag;
                        cnt_reg     <= '0;
                        if (special) begin
                            result_reg <= special_val;
                        end
                    end
                end
                S_MUL: begin
                    acc_reg    <= acc_reg + mul_add;
                    mcand_reg  <= mcand_reg << MUL_STEP;
                    mplier_reg <= mplier_reg >> MUL_STEP;
                    cnt_reg    <= cnt_reg + CW'(1);
                end
                S_DIV: begin
                    rem_reg <= rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
                    quo_reg <= {quo_reg[XLEN-2:0], rem_ge};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                S_FIXUP: begin
                    result_reg <= fix_result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_unit_iter.sv
// Testbench for m_unit_iter. It drives a 32-bit/step-1 instance and a 16-bit/step-4 instance.
// Results and latencies are compared against an arithmetic reference model of the M-extension.
module tb_m_unit_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        flush     [2];
    logic        out_ready [2];
    logic [2:0]  op_s      [2];
    logic [31:0] opa       [2];
    logic [31:0] opb       [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        busy      [2];
    logic [31:0] res       [2];
    logic [15:0] res16;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    m_unit_iter #(.XLEN(32), .MUL_STEP(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op_s[0]), .operand_a(opa[0]), .operand_b(opb[0]), .flush(flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(res[0]), .busy(busy[0])
    );

    m_unit_iter #(.XLEN(16), .MUL_STEP(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op_s[1]), .operand_a(opa[1][15:0]), .operand_b(opb[1][15:0]), .flush(flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(res16), .busy(busy[1])
    );

    assign res[1] = {16'h0000, res16};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result from the ISA arithmetic rules
    function automatic logic [31:0] model(input int xlen, input logic [2:0] o,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      mask, minv, ua, ub, sa, sb, p;
        logic [63:0] pu;
        mask = (longint'(1) <<< xlen) - 1;
        minv = longint'(1) <<< (xlen - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= minv) ? ua - (longint'(1) <<< xlen) : ua;
        sb   = (ub >= minv) ? ub - (longint'(1) <<< xlen) : ub;
        case (o)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >>> xlen;
            3'd2: p = (sa * ub) >>> xlen;
            3'd3: begin pu = 64'(ua) * 64'(ub); p = longint'(pu >> xlen); end
            3'd4: p = (ub == 0) ? mask : ((sa == -minv && sb == -1) ? -minv : sa / sb);
            3'd5: p = (ub == 0) ? mask : ua / ub;
            3'd6: p = (ub == 0) ? ua : ((sa == -minv && sb == -1) ? 0 : sa % sb);
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(p & mask);
    endfunction

    function automatic int model_lat(input int xlen, input int step, input logic [2:0] o,
                                     input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask, minv;
        mask = 32'((64'd1 << xlen) - 1);
        minv = 32'(64'd1 << (xlen - 1));
        if (!o[2]) return xlen / step + 2;
        if ((b & mask) == 0) return 1;
        if (!o[0] && (a & mask) == minv && (b & mask) == mask) return 1;
        return xlen + 2;
    endfunction

    function automatic logic [31:0] pick(input int xlen);
        logic [31:0] v;
        case ($urandom % 6)
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd1 << (xlen - 1);
            4: begin v = $urandom % 16; if ($urandom % 2 == 1) v = -v; end
            default: v = $urandom;
        endcase
        return 32'(64'(v) & ((64'd1 << xlen) - 1));
    endfunction

    // One full transaction: request, latency/result check, optional stall, handshake
    task automatic do_op(input int sel, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int hold);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        in_valid[sel] = 1'b1; op_s[sel] = o; opa[sel] = a; opb[sel] = b; out_ready[sel] = 1'b0;
        #1 check("in_ready_before", 32'(in_ready[sel]), 32'd1);
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid[sel] && lat < 300) begin
            in_valid[sel] = 1'($urandom);
            op_s[sel]     = 3'($urandom);
            opa[sel]      = $urandom;
            opb[sel]      = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        in_valid[sel] = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", res[sel], exp_res);
        check("in_ready_done", 32'(in_ready[sel]), 32'd0);
        held = res[sel];
        repeat (hold) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid[sel]), 32'd1);
            check("stall_stable", res[sel], held);
        end
        out_ready[sel] = 1'b1;
        @(posedge clk); #1;
        out_ready[sel] = 1'b0;
        check("valid_after_hs", 32'(out_valid[sel]), 32'd0);
        check("ready_after_hs", 32'(in_ready[sel]), 32'd1);
        $display("txn dut%0d op=%0d a=%h b=%h result=%h expected=%h latency=%0d",
                 sel, o, a, b, held, exp_res, lat);
    endtask

    initial begin
        int any_valid;
        int xl, st;
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0; flush[s] = 1'b0; out_ready[s] = 1'b0;
            op_s[s] = 3'd0; opa[s] = 32'd0; opb[s] = 32'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_out_valid", 32'(out_valid[s]), 32'd0);
            check("rst_in_ready", 32'(in_ready[s]), 32'd1);
            check("rst_busy", 32'(busy[s]), 32'd0);
            check("rst_result", res[s], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, 32-bit instance
        do_op(0, 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34, 0);
        do_op(0, 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 34, 0);
        do_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        do_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        do_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        do_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
        do_op(0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        do_op(0, 3'd6, 32'd7, 32'd0, 32'd7, 1, 0);
        do_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        do_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 5);

        // Flush in the middle of a divide
        @(negedge clk);
        in_valid[0] = 1'b1; op_s[0] = 3'd4; opa[0] = 32'd100; opb[0] = 32'd7;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        check("flush_valid", 32'(out_valid[0]), 32'd0);
        check("flush_ready", 32'(in_ready[0]), 32'd1);
        any_valid = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid[0]) any_valid = 1;
        end
        check("flush_no_result", 32'(any_valid), 32'd0);
        do_op(0, 3'd0, 32'd6, 32'd7, 32'd42, 34, 0);

        // Flush together with a request in IDLE: request dropped
        @(negedge clk);
        in_valid[0] = 1'b1; flush[0] = 1'b1; op_s[0] = 3'd0; opa[0] = 32'd3; opb[0] = 32'd3;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; flush[0] = 1'b0;
        check("flush_idle_busy", 32'(busy[0]), 32'd0);

        // Reset mid-operation clears the held result
        @(negedge clk);
        in_valid[0] = 1'b1; op_s[0] = 3'd0; opa[0] = 32'd9; opb[0] = 32'd9;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_result", res[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, 16-bit / step-4 instance
        do_op(1, 3'd1, 32'h0000_FFFE, 32'd3, 32'h0000_FFFF, 6, 0);
        do_op(1, 3'd0, 32'h0000_FFFE, 32'd3, 32'h0000_FFFA, 6, 0);
        do_op(1, 3'd4, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 1, 0);
        do_op(1, 3'd4, 32'h0000_FFF9, 32'd2, 32'h0000_FFFD, 18, 5);

        // Randomized operations on both instances
        for (int i = 0; i < 40; i++) begin
            for (int s = 0; s < 2; s++) begin
                xl = (s == 0) ? 32 : 16;
                st = (s == 0) ? 1 : 4;
                o  = 3'($urandom);
                a  = pick(xl);
                b  = pick(xl);
                do_op(s, o, a, b, model(xl, o, a, b), model_lat(xl, st, o, a, b),
                      int'($urandom % 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
